// File: rtl/fib_check_if.sv
// Sample stream and checker status bundle for fib_check.
// The master side drives samples; the slave side (the checker) reports status.
interface fib_check_if;
    logic       in_valid;
    logic [3:0] in_data;
    logic       locked;
    logic       err;
    logic [7:0] err_cnt;
    logic       frame_done;
    logic [7:0] frame_cnt;

    modport master (
        output in_valid, in_data,
        input  locked, err, err_cnt, frame_done, frame_cnt
    );

    modport slave (
        input  in_valid, in_data,
        output locked, err, err_cnt, frame_done, frame_cnt
    );
endinterface

// File: rtl/fib_check.sv
// Fibonacci frame checker: locks onto seed-1 frames of FRAME_LEN samples,
// checks each sample against (prev + cur) mod 16 and reports errors/frames.
module fib_check #(
    parameter int FRAME_LEN = 8
) (
    input  logic     clk,
    input  logic     rst,
    fib_check_if.slave bus
);
    localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

    typedef enum logic [1:0] {HUNT, START, TRACK} state_t;

    typedef struct packed {
        logic [3:0] prev;
        logic [3:0] cur;
        logic [3:0] idx;
    } trk_t;

    localparam trk_t TRK_SEED = '{prev: 4'd0, cur: 4'd1, idx: 4'd1};

    state_t     state, state_n;
    trk_t       trk, trk_n;
    logic       locked, locked_n;
    logic       err, err_n;
    logic       done, done_n;
    logic [7:0] err_cnt, err_cnt_n;
    logic [7:0] frame_cnt, frame_cnt_n;

    logic [3:0] expected;
    logic       is_seed;
    logic       is_match;
    logic       is_last;
    logic [7:0] err_cnt_inc;

    // 4-bit add drops the carry, giving the mod-16 Fibonacci step.
    assign expected    = trk.prev + trk.cur;
    assign is_seed     = (bus.in_data == 4'd1);
    assign is_match    = (bus.in_data == expected);
    assign is_last     = (trk.idx == LAST_IDX);
    assign err_cnt_inc = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HUNT;
            trk       <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
            done      <= 1'b0;
            err_cnt   <= '0;
            frame_cnt <= '0;
        end else begin
            state     <= state_n;
            trk       <= trk_n;
            locked    <= locked_n;
            err       <= err_n;
            done      <= done_n;
            err_cnt   <= err_cnt_n;
            frame_cnt <= frame_cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        trk_n       = trk;
        locked_n    = locked;
        err_n       = 1'b0;
        done_n      = 1'b0;
        err_cnt_n   = err_cnt;
        frame_cnt_n = frame_cnt;

        if (bus.in_valid) begin
            unique case (state)
                HUNT: begin
                    if (is_seed) begin
                        trk_n   = TRK_SEED;
                        state_n = TRACK;
                    end
                end
                START: begin
                    if (is_seed) begin
                        trk_n   = TRK_SEED;
                        state_n = TRACK;
                    end else begin
                        err_n     = 1'b1;
                        err_cnt_n = err_cnt_inc;
                        locked_n  = 1'b0;
                        state_n   = HUNT;
                    end
                end
                TRACK: begin
                    if (is_match) begin
                        trk_n.prev = trk.cur;
                        trk_n.cur  = bus.in_data;
                        trk_n.idx  = trk.idx + 4'd1;
                        if (is_last) begin
                            done_n      = 1'b1;
                            frame_cnt_n = frame_cnt + 8'd1;
                            locked_n    = 1'b1;
                            trk_n.idx   = 4'd0;
                            state_n     = START;
                        end
                    end else begin
                        err_n     = 1'b1;
                        err_cnt_n = err_cnt_inc;
                        locked_n  = 1'b0;
                        // A mismatching 1 may be the start of a fresh frame.
                        if (is_seed) begin
                            trk_n = TRK_SEED;
                        end else begin
                            state_n = HUNT;
                        end
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    assign bus.locked     = locked;
    assign bus.err        = err;
    assign bus.err_cnt    = err_cnt;
    assign bus.frame_done = done;
    assign bus.frame_cnt  = frame_cnt;

    a_err_done_excl: assert property (@(posedge clk) disable iff (rst) !(err && done));
endmodule

// File: tb/tb_fib_check.sv
// Self-checking bench for fib_check: vector table, directed corner sequences
// and randomized streams against a frame-position reference model.
module tb_fib_check;
    localparam int FL = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    fib_check_if bus();

    fib_check #(.FRAME_LEN(FL)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: position within the frame plus a Fibonacci lookup.
    int fib[16];
    int m_pos;
    bit m_locked, m_err, m_fd;
    int m_ec, m_fc;

    typedef struct {
        bit       v;
        bit [3:0] d;
        bit       e;
        bit       f;
        bit       l;
        int       ec;
        int       fc;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(bit v, bit [3:0] d, bit e, bit f, bit l, int ec, int fc);
        vec_t x;
        x.v = v; x.d = d; x.e = e; x.f = f; x.l = l; x.ec = ec; x.fc = fc;
        tbl.push_back(x);
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pos = 0; m_locked = 0; m_err = 0; m_fd = 0; m_ec = 0; m_fc = 0;
    endfunction

    function automatic void model_step(bit v, bit [3:0] d);
        m_err = 0;
        m_fd  = 0;
        if (!v) return;
        if (m_pos == 0) begin
            if (d == 1) m_pos = 1;
            else if (m_locked) begin
                m_err = 1; m_locked = 0;
                if (m_ec < 255) m_ec++;
            end
        end else if (int'(d) == fib[m_pos]) begin
            m_pos++;
            if (m_pos == FL) begin
                m_fd = 1; m_locked = 1; m_pos = 0;
                m_fc = (m_fc + 1) % 256;
            end
        end else begin
            m_err = 1; m_locked = 0;
            if (m_ec < 255) m_ec++;
            m_pos = (d == 1) ? 1 : 0;
        end
    endfunction

    task automatic cmp_model(string tag);
        chk({tag, ".err"}, int'(bus.err), int'(m_err));
        chk({tag, ".frame_done"}, int'(bus.frame_done), int'(m_fd));
        chk({tag, ".locked"}, int'(bus.locked), int'(m_locked));
        chk({tag, ".err_cnt"}, int'(bus.err_cnt), m_ec);
        chk({tag, ".frame_cnt"}, int'(bus.frame_cnt), m_fc);
    endtask

    // Drive one cycle; returns with outputs settled 1 time unit past the edge.
    task automatic step(bit v, bit [3:0] d, bit do_cmp, string tag);
        bus.in_valid = v;
        bus.in_data  = d;
        @(posedge clk);
        model_step(v, d);
        #1;
        if (do_cmp) cmp_model(tag);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, ".err"}, int'(bus.err), 0);
        chk({tag, ".frame_done"}, int'(bus.frame_done), 0);
        chk({tag, ".locked"}, int'(bus.locked), 0);
        chk({tag, ".err_cnt"}, int'(bus.err_cnt), 0);
        chk({tag, ".frame_cnt"}, int'(bus.frame_cnt), 0);
    endtask

    // Reset is raised between edges with a valid seed on the bus to show it wins.
    task automatic do_reset(string tag);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'd1;
        #2 rst = 1'b1;
        #1 chk_zero({tag, ".rst_async"});
        @(posedge clk);
        #1 chk_zero({tag, ".rst_hold"});
        rst = 1'b0;
        bus.in_valid = 1'b0;
        model_reset();
    endtask

    task automatic good_frame(string tag);
        for (int k = 0; k < FL; k++) step(1'b1, 4'(fib[k]), 1'b1, tag);
    endtask

    initial begin
        int fd_n, err_n, last_fd, err_at, fd_at;
        bit [3:0] rd;

        fib[0] = 1; fib[1] = 1;
        for (int k = 2; k < 16; k++) fib[k] = (fib[k-1] + fib[k-2]) % 16;
        model_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = 4'd0;
        repeat (2) @(posedge clk);
        #1;

        // Good frame, corrupted frame, ignored junk in HUNT, good frame.
        do_reset("tbl");
        add(1, 1, 0, 0, 0, 0, 0);  add(1, 1, 0, 0, 0, 0, 0);
        add(1, 2, 0, 0, 0, 0, 0);  add(1, 3, 0, 0, 0, 0, 0);
        add(1, 5, 0, 0, 0, 0, 0);  add(1, 8, 0, 0, 0, 0, 0);
        add(1, 13, 0, 0, 0, 0, 0); add(1, 5, 0, 1, 1, 0, 1);
        add(1, 1, 0, 0, 1, 0, 1);  add(1, 1, 0, 0, 1, 0, 1);
        add(1, 2, 0, 0, 1, 0, 1);  add(1, 4, 1, 0, 0, 1, 1);
        add(1, 0, 0, 0, 0, 1, 1);  add(1, 7, 0, 0, 0, 1, 1);
        add(0, 1, 0, 0, 0, 1, 1);
        add(1, 1, 0, 0, 0, 1, 1);  add(1, 1, 0, 0, 0, 1, 1);
        add(1, 2, 0, 0, 0, 1, 1);  add(1, 3, 0, 0, 0, 1, 1);
        add(1, 5, 0, 0, 0, 1, 1);  add(1, 8, 0, 0, 0, 1, 1);
        add(1, 13, 0, 0, 0, 1, 1); add(1, 5, 0, 1, 1, 1, 2);
        add(1, 9, 1, 0, 0, 2, 2);
        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].d, 1'b0, "tbl");
            chk($sformatf("tbl[%0d].err", i), int'(bus.err), int'(tbl[i].e));
            chk($sformatf("tbl[%0d].frame_done", i), int'(bus.frame_done), int'(tbl[i].f));
            chk($sformatf("tbl[%0d].locked", i), int'(bus.locked), int'(tbl[i].l));
            chk($sformatf("tbl[%0d].err_cnt", i), int'(bus.err_cnt), tbl[i].ec);
            chk($sformatf("tbl[%0d].frame_cnt", i), int'(bus.frame_cnt), tbl[i].fc);
        end

        // Ten back-to-back frames: pulses 8 cycles apart, locked never drops.
        do_reset("b2b");
        fd_n = 0; err_n = 0; last_fd = -1;
        for (int c = 0; c < 10 * FL; c++) begin
            step(1'b1, 4'(fib[c % FL]), 1'b1, "b2b");
            if (bus.err) err_n++;
            if (bus.frame_done) begin
                if (last_fd >= 0) chk("b2b.spacing", c - last_fd, FL);
                last_fd = c;
                fd_n++;
            end
            if (fd_n > 0 && !bus.locked) chk("b2b.locked_held", 0, 1);
        end
        chk("b2b.frames", fd_n, 10);
        chk("b2b.errs", err_n, 0);
        chk("b2b.frame_cnt", int'(bus.frame_cnt), 10);

        // Mismatching 1 reseeds mid-frame.
        do_reset("reseed");
        err_at = -1; fd_at = -1; err_n = 0;
        begin
            int seq[12] = '{1, 1, 2, 3, 1, 1, 2, 3, 5, 8, 13, 5};
            for (int c = 0; c < 12; c++) begin
                step(1'b1, 4'(seq[c]), 1'b1, "reseed");
                if (bus.err) begin err_n++; err_at = c; end
                if (bus.frame_done) fd_at = c;
            end
        end
        chk("reseed.err_count", err_n, 1);
        chk("reseed.err_at", err_at, 4);
        chk("reseed.fd_at", fd_at, 11);
        chk("reseed.err_cnt", int'(bus.err_cnt), 1);
        chk("reseed.frame_cnt", int'(bus.frame_cnt), 1);

        // Valid gap of 3 cycles inside a frame delays completion by 3.
        do_reset("gap");
        fd_at = -1; err_n = 0;
        for (int c = 0; c < FL + 3; c++) begin
            if (c >= 3 && c < 6) step(1'b0, 4'(c + 7), 1'b1, "gap");
            else step(1'b1, 4'(fib[(c < 3) ? c : c - 3]), 1'b1, "gap");
            if (bus.err) err_n++;
            if (bus.frame_done) fd_at = c;
        end
        chk("gap.fd_at", fd_at, FL + 2);
        chk("gap.errs", err_n, 0);
        chk("gap.locked", int'(bus.locked), 1);
        chk("gap.frame_cnt", int'(bus.frame_cnt), 1);

        // Reset mid-frame, then a clean frame, then saturate err_cnt.
        do_reset("midrst");
        for (int k = 0; k < 5; k++) step(1'b1, 4'(fib[k]), 1'b1, "midrst");
        do_reset("midrst");
        good_frame("midrst");
        chk("midrst.frame_cnt", int'(bus.frame_cnt), 1);
        chk("midrst.err_cnt", int'(bus.err_cnt), 0);
        for (int n = 0; n < 300; n++) begin
            step(1'b1, 4'd1, 1'b1, "sat");
            step(1'b1, 4'd2, 1'b1, "sat");
        end
        chk("sat.err_cnt", int'(bus.err_cnt), 255);
        chk("sat.locked", int'(bus.locked), 0);

        // Randomized streams, mostly on-sequence with occasional corruption.
        do_reset("rand");
        for (int c = 0; c < 3000; c++) begin
            rd = (($urandom % 10) < 8) ? 4'((m_pos == 0) ? 1 : fib[m_pos]) : 4'($urandom % 16);
            step(($urandom % 8) != 0, rd, 1'b1, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fib_check.md
FIB_CHECK -- requirements
Module: fib_check

Interface
REQ-001 Parameter FRAME_LEN, default 8, SHALL give the samples per frame including the seed; legal range 3..15.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 in_valid  input  1  SHALL qualify in_data; upstream with no valid tie-off drives it constant 1.
REQ-005 in_data  input  4  SHALL be the sample from the upstream Fibonacci generator.
REQ-006 locked  output  1  SHALL be high while a frame checked error-free is in progress or just completed.
REQ-007 err  output  1  SHALL be a one-cycle pulse per mismatching sample.
REQ-008 err_cnt  output  8  SHALL count mismatches.
REQ-009 frame_done  output  1  SHALL be a one-cycle pulse per error-free completed frame.
REQ-010 frame_cnt  output  8  SHALL count error-free completed frames.

Function
REQ-011 All outputs SHALL be registered; the response to a sample SHALL appear the cycle after the clk edge that samples it with in_valid=1.
REQ-012 With in_valid=0, state, prev, cur, idx and counters SHALL hold; err and frame_done SHALL be 0.
REQ-013 Internal prev, cur (4 bits each) and idx (4 bits) SHALL track the frame; expected value = (prev + cur) mod 16, carry discarded (13+8 -> 5).
REQ-014 FSM states SHALL be HUNT, START and TRACK.
REQ-015 HUNT, valid sample == 1: set prev=0, cur=1, idx=1 and go to TRACK; valid sample != 1: ignore it, no err, stay.
REQ-016 START (expects the next frame's seed), valid sample == 1: behave as in HUNT, locked stays 1.
REQ-017 START, valid sample != 1: pulse err, bump err_cnt, clear locked and go to HUNT.
REQ-018 TRACK, valid sample == expected: set prev=cur, cur=sample, idx=idx+1.
REQ-019 TRACK, match with idx == FRAME_LEN-1 (last sample): pulse frame_done, bump frame_cnt, set locked=1, set idx=0 and go to START.
REQ-020 TRACK, mismatch: pulse err, bump err_cnt and clear locked.
REQ-021 On that mismatch, a sample equal to 1 SHALL be taken as a new seed (prev=0, cur=1, idx=1, stay TRACK); any other value SHALL go to HUNT.
REQ-022 err_cnt SHALL saturate at 255.
REQ-023 frame_cnt SHALL wrap 255 -> 0.
REQ-024 err and frame_done SHALL never assert in the same cycle.
REQ-025 locked SHALL rise only on a frame_done cycle and fall only on an err cycle.
REQ-026 No backpressure SHALL exist; every valid sample is consumed in its cycle.

Reset
REQ-027 rst=1 SHALL asynchronously force state=HUNT, prev=cur=idx=0, locked=err=frame_done=0, err_cnt=frame_cnt=0.
REQ-028 rst SHALL override any simultaneous valid sample.
REQ-029 rst asserted mid-frame SHALL discard the partial frame without err or frame_done.
REQ-030 After rst deasserts, the first valid sample SHALL be evaluated under HUNT rules.

Verification (FRAME_LEN=8, in_valid=1 unless stated)
REQ-031 Reset, then stream 1,1,2,3,5,8,13,5 -> frame_done pulse the cycle after the 5; locked=1; frame_cnt=1; err_cnt=0.
REQ-032 Ten back-to-back frames as REQ-031 -> ten frame_done pulses 8 cycles apart; locked stays 1 from the first pulse; frame_cnt=10; err never asserts.
REQ-033 One good frame, then 1,1,2,4 -> err pulse the cycle after the 4; locked=0; err_cnt=1; then 0,7 ignored; then a full good frame -> frame_done, locked=1.
REQ-034 Stream 1,1,2,3,1,1,2,3,5,8,13,5 -> one err at the 5th sample (1 != 5), reseeded there; frame_done after the final 5; err_cnt=1, frame_cnt=1.
REQ-035 Good frame with in_valid low for 3 cycles between the 2 and the 3 -> no err; frame_done timing shifts by 3 cycles; counters as in REQ-031.
REQ-036 rst pulsed after sample 5 of a frame, then a full frame -> all outputs 0 during rst; then one frame_done, frame_cnt=1; 300 forced mismatches -> err_cnt holds at 255.
